// File: rtl/train_pkg.sv
// Shared types and constants for the training-step sequencer and its learning-rate schedule.
package train_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ACCUM,
        S_LATCH,
        S_LOAD,
        S_START,
        S_WAIT,
        S_STORE,
        S_FINISH,
        S_ERR
    } state_e;

    localparam int          LR_SHIFT_MAX = 15;
    localparam int          WARMUP_SHIFT = 2;
    localparam logic [15:0] ONE          = 16'h0100;

endpackage

// File: rtl/lr_scheduler.sv
// Step-decay learning rate with warmup: counts completed steps and halves the rate every decay interval.
module lr_scheduler
    import train_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  step_inc_i,
    input  logic [31:0]           step_count_i,
    input  logic [DATA_WIDTH-1:0] base_lr_i,
    input  logic [15:0]           warmup_i,
    input  logic [15:0]           decay_int_i,
    output logic [DATA_WIDTH-1:0] lr_o
);

    logic [3:0]            lvl_q, lvl_d;
    logic [15:0]           since_q, since_d;
    logic [16:0]           since_inc;
    logic [DATA_WIDTH-1:0] lr_q, lr_d;

    // Decay is a compare against the interval followed by a shift; no divider needed.
    always_comb begin
        since_inc = {1'b0, since_q} + 17'd1;
        lvl_d     = lvl_q;
        since_d   = since_q;
        if (step_inc_i && (decay_int_i != 16'd0)) begin
            if (since_inc >= {1'b0, decay_int_i}) begin
                since_d = '0;
                if (lvl_q != 4'(LR_SHIFT_MAX)) begin
                    lvl_d = lvl_q + 4'd1;
                end
            end else begin
                since_d = since_inc[15:0];
            end
        end
    end

    always_comb begin
        if (step_count_i < {16'd0, warmup_i}) begin
            lr_d = base_lr_i >> WARMUP_SHIFT;
        end else begin
            lr_d = base_lr_i >> lvl_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q   <= '0;
            since_q <= '0;
        end else begin
            lvl_q   <= lvl_d;
            since_q <= since_d;
        end
    end

    always_ff @(posedge clk) begin
        lr_q <= lr_d;
    end

    assign lr_o = lr_q;

endmodule

// File: rtl/weight_update_scheduler.sv
// Sequences the shared weight update unit over every layer once per optimizer step,
// after a configurable number of mini-batch gradient arrivals.
module weight_update_scheduler
    import train_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_LAYERS = 8,
    parameter int ACCUM_W    = 4,
    parameter int TIMEOUT    = 1024,
    localparam int LAYER_W   = $clog2(MAX_LAYERS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  enable,
    input  logic                  grad_ready,
    input  logic [LAYER_W:0]      cfg_num_layers,
    input  logic [ACCUM_W-1:0]    cfg_accum,
    input  logic [DATA_WIDTH-1:0] cfg_base_lr,
    input  logic [15:0]           cfg_warmup,
    input  logic [15:0]           cfg_decay_int,
    output logic                  ld_req,
    input  logic                  ld_ack,
    output logic                  st_req,
    input  logic                  st_ack,
    output logic [LAYER_W-1:0]    mem_layer,
    output logic                  uu_start,
    output logic                  uu_clear,
    input  logic                  uu_done,
    output logic [DATA_WIDTH-1:0] uu_lr,
    output logic [31:0]           uu_timestep,
    output logic [31:0]           step_count,
    output logic                  busy,
    output logic                  step_done,
    output logic                  timeout_err
);

    localparam int WD_W = $clog2(TIMEOUT + 1) + 1;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    state_e                state_q;
    logic [ACCUM_W-1:0]    accum_cnt_q, accum_cnt_d, accum_eff;
    logic [LAYER_W-1:0]    layer_q;
    logic [LAYER_W:0]      num_eff;
    logic [WD_W-1:0]       wd_q;
    logic                  ld_req_q, st_req_q, uu_start_q, uu_clear_q;
    logic                  step_done_q, timeout_err_q;
    logic [DATA_WIDTH-1:0] uu_lr_q, lr_sched;
    logic [31:0]           timestep_q, step_count_q;
    logic                  accum_inc, accum_full, start_step, last_layer, busy_w;

    always_comb begin
        accum_eff = (cfg_accum == '0) ? ACCUM_W'(1) : cfg_accum;
        if (cfg_num_layers == '0) begin
            num_eff = (LAYER_W+1)'(1);
        end else if (cfg_num_layers > (LAYER_W+1)'(MAX_LAYERS)) begin
            num_eff = (LAYER_W+1)'(MAX_LAYERS);
        end else begin
            num_eff = cfg_num_layers;
        end
    end

    assign last_layer = ({1'b0, layer_q} == (num_eff - (LAYER_W+1)'(1)));
    assign busy_w     = (state_q != S_IDLE) && (state_q != S_ACCUM);

    // Gradient arrivals keep counting while a step runs, saturating at one full step's worth.
    always_comb begin
        accum_inc   = enable & grad_ready;
        accum_full  = (accum_cnt_q >= accum_eff);
        start_step  = (state_q == S_ACCUM) && enable && !clear && accum_full;
        accum_cnt_d = accum_cnt_q;
        if (start_step) begin
            accum_cnt_d = ACCUM_W'(accum_inc);
        end else if (accum_inc && !accum_full) begin
            accum_cnt_d = accum_cnt_q + ACCUM_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accum_cnt_q <= '0;
        end else begin
            accum_cnt_q <= accum_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            layer_q       <= '0;
            wd_q          <= '0;
            ld_req_q      <= 1'b0;
            st_req_q      <= 1'b0;
            uu_start_q    <= 1'b0;
            uu_clear_q    <= 1'b0;
            step_done_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            uu_lr_q       <= '0;
            timestep_q    <= '0;
            step_count_q  <= '0;
        end else begin
            uu_start_q  <= 1'b0;
            uu_clear_q  <= 1'b0;
            step_done_q <= 1'b0;
            if (clear) begin
                state_q       <= S_IDLE;
                ld_req_q      <= 1'b0;
                st_req_q      <= 1'b0;
                timeout_err_q <= 1'b0;
                uu_clear_q    <= busy_w;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (enable) state_q <= S_ACCUM;
                    end
                    S_ACCUM: begin
                        if (!enable) begin
                            state_q <= S_IDLE;
                        end else if (accum_full) begin
                            state_q <= S_LATCH;
                        end
                    end
                    S_LATCH: begin
                        uu_lr_q    <= lr_sched;
                        timestep_q <= sat_inc32(step_count_q);
                        layer_q    <= '0;
                        ld_req_q   <= 1'b1;
                        state_q    <= S_LOAD;
                    end
                    S_LOAD: begin
                        if (ld_ack) begin
                            ld_req_q   <= 1'b0;
                            uu_start_q <= 1'b1;
                            state_q    <= S_START;
                        end
                    end
                    S_START: begin
                        wd_q    <= '0;
                        state_q <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (uu_done) begin
                            st_req_q <= 1'b1;
                            state_q  <= S_STORE;
                        end else if (wd_q >= WD_W'(TIMEOUT)) begin
                            timeout_err_q <= 1'b1;
                            uu_clear_q    <= 1'b1;
                            state_q       <= S_ERR;
                        end else begin
                            wd_q <= wd_q + WD_W'(1);
                        end
                    end
                    S_STORE: begin
                        if (st_ack) begin
                            st_req_q <= 1'b0;
                            if (last_layer) begin
                                step_count_q <= sat_inc32(step_count_q);
                                timestep_q   <= sat_inc32(sat_inc32(step_count_q));
                                step_done_q  <= 1'b1;
                                state_q      <= S_FINISH;
                            end else begin
                                layer_q  <= layer_q + LAYER_W'(1);
                                ld_req_q <= 1'b1;
                                state_q  <= S_LOAD;
                            end
                        end
                    end
                    S_FINISH: begin
                        state_q <= enable ? S_ACCUM : S_IDLE;
                    end
                    S_ERR: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    lr_scheduler #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_lr_scheduler (
        .clk          (clk),
        .rst_n        (rst_n),
        .step_inc_i   (step_done_q),
        .step_count_i (step_count_q),
        .base_lr_i    (cfg_base_lr),
        .warmup_i     (cfg_warmup),
        .decay_int_i  (cfg_decay_int),
        .lr_o         (lr_sched)
    );

    assign ld_req      = ld_req_q;
    assign st_req      = st_req_q;
    assign mem_layer   = layer_q;
    assign uu_start    = uu_start_q;
    assign uu_clear    = uu_clear_q;
    assign uu_lr       = uu_lr_q;
    assign uu_timestep = timestep_q;
    assign step_count  = step_count_q;
    assign busy        = busy_w;
    assign step_done   = step_done_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_weight_update_scheduler.sv
// Scoreboard bench: a memory/unit responder acks one cycle late; expected handshakes and step results are queued per step.
module tb_weight_update_scheduler;

    localparam int DW = 16;
    localparam int ML = 8;
    localparam int AW = 4;
    localparam int TO = 1024;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          clear = 1'b0;
    logic          enable = 1'b0;
    logic          grad_ready = 1'b0;
    logic [LW:0]   cfg_num_layers;
    logic [AW-1:0] cfg_accum;
    logic [DW-1:0] cfg_base_lr;
    logic [15:0]   cfg_warmup;
    logic [15:0]   cfg_decay_int;
    logic          ld_req, ld_ack, st_req, st_ack;
    logic [LW-1:0] mem_layer;
    logic          uu_start, uu_clear, uu_done;
    logic [DW-1:0] uu_lr;
    logic [31:0]   uu_timestep, step_count;
    logic          busy, step_done, timeout_err;

    weight_update_scheduler #(
        .DATA_WIDTH(DW), .MAX_LAYERS(ML), .ACCUM_W(AW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .enable(enable), .grad_ready(grad_ready),
        .cfg_num_layers(cfg_num_layers), .cfg_accum(cfg_accum), .cfg_base_lr(cfg_base_lr),
        .cfg_warmup(cfg_warmup), .cfg_decay_int(cfg_decay_int),
        .ld_req(ld_req), .ld_ack(ld_ack), .st_req(st_req), .st_ack(st_ack),
        .mem_layer(mem_layer), .uu_start(uu_start), .uu_clear(uu_clear), .uu_done(uu_done),
        .uu_lr(uu_lr), .uu_timestep(uu_timestep), .step_count(step_count),
        .busy(busy), .step_done(step_done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] sc;
        logic [15:0] lr;
        logic [31:0] ts;
    } step_t;

    int    checks = 0;
    int    errors = 0;
    int    q_ld[$];
    int    q_st[$];
    step_t q_step[$];
    int    n_start = 0, n_clr = 0, n_done = 0, n_ldreq = 0, n_st = 0;
    int    ld_age = 0, st_age = 0, dcnt = 0, done_lat = 5;
    bit    hold_done = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_lr(input int k);
        int lvl;
        if (k < int'(cfg_warmup)) return cfg_base_lr >> 2;
        lvl = (cfg_decay_int == 16'd0) ? 0 : k / int'(cfg_decay_int);
        if (lvl > 15) lvl = 15;
        return cfg_base_lr >> lvl;
    endfunction

    task automatic push_step(input int k, input int n);
        step_t s;
        for (int i = 0; i < n; i++) begin
            q_ld.push_back(i);
            q_st.push_back(i);
        end
        s.sc = 32'(k + 1);
        s.lr = exp_lr(k);
        s.ts = 32'(k + 2);
        q_step.push_back(s);
    endtask

    task automatic pulse_grad();
        @(negedge clk);
        grad_ready = 1'b1;
        @(negedge clk);
        grad_ready = 1'b0;
    endtask

    task automatic wait_step(input string tag);
        int t;
        int base;
        t = 0;
        base = n_done;
        while (n_done == base && t < 300) begin
            @(negedge clk);
            t++;
        end
        check(tag, 64'(n_done - base), 64'd1);
    endtask

    // Responder and monitor share one negedge process so acks and observations never race.
    initial begin
        step_t s;
        ld_ack = 1'b0;
        st_ack = 1'b0;
        uu_done = 1'b0;
        forever begin
            @(negedge clk);
            ld_age = ld_req ? ld_age + 1 : 0;
            st_age = st_req ? st_age + 1 : 0;
            ld_ack = (ld_age == 2);
            st_ack = (st_age == 2);
            uu_done = 1'b0;
            if (uu_clear || !rst_n) begin
                dcnt = 0;
            end else if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0 && !hold_done) uu_done = 1'b1;
            end
            if (uu_start) dcnt = done_lat;
            if (rst_n) begin
                if (ld_req) n_ldreq++;
                if (uu_start) n_start++;
                if (uu_clear) n_clr++;
                if (ld_req && ld_ack) begin
                    if (q_ld.size() == 0) check("ld_unexpected", 64'd1, 64'd0);
                    else check("ld_layer", 64'(mem_layer), 64'(q_ld.pop_front()));
                end
                if (st_req && st_ack) begin
                    n_st++;
                    if (q_st.size() == 0) check("st_unexpected", 64'd1, 64'd0);
                    else check("st_layer", 64'(mem_layer), 64'(q_st.pop_front()));
                end
                if (step_done) begin
                    n_done++;
                    if (q_step.size() == 0) begin
                        check("step_unexpected", 64'd1, 64'd0);
                    end else begin
                        s = q_step.pop_front();
                        check("step_count", 64'(step_count), 64'(s.sc));
                        check("uu_lr", 64'(uu_lr), 64'(s.lr));
                        check("uu_timestep", 64'(uu_timestep), 64'(s.ts));
                    end
                end
            end
        end
    end

    initial begin
        int t;
        int base;
        int base2;
        cfg_num_layers = 4'd3;
        cfg_accum      = 4'd1;
        cfg_base_lr    = 16'h0100;
        cfg_warmup     = 16'd2;
        cfg_decay_int  = 16'd3;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ld_req", 64'(ld_req), 64'd0);
        check("rst_st_req", 64'(st_req), 64'd0);
        check("rst_uu_start", 64'(uu_start), 64'd0);
        check("rst_uu_clear", 64'(uu_clear), 64'd0);
        check("rst_uu_lr", 64'(uu_lr), 64'd0);
        check("rst_timestep", 64'(uu_timestep), 64'd0);
        check("rst_step_count", 64'(step_count), 64'd0);
        check("rst_busy_done_err", 64'({busy, step_done, timeout_err}), 64'd0);
        rst_n  = 1'b1;
        enable = 1'b1;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 4; k++) begin
            push_step(k, 3);
            pulse_grad();
            wait_step("step_done_wait");
        end
        repeat (3) @(negedge clk);
        check("starts_4x3", 64'(n_start), 64'd12);
        check("done_pulses", 64'(n_done), 64'd4);
        check("step_count_4", 64'(step_count), 64'd4);
        check("timestep_5", 64'(uu_timestep), 64'd5);

        cfg_accum = 4'd4;
        base = n_ldreq;
        repeat (3) pulse_grad();
        repeat (30) @(negedge clk);
        check("accum3_no_ld", 64'(n_ldreq - base), 64'd0);
        check("accum3_not_busy", 64'(busy), 64'd0);
        push_step(4, 3);
        pulse_grad();
        wait_step("accum4_step");

        cfg_accum = 4'd1;
        hold_done = 1'b1;
        q_ld.push_back(0);
        base = n_clr;
        pulse_grad();
        t = 0;
        while (!timeout_err && t < 1300) begin
            @(negedge clk);
            t++;
        end
        check("timeout_err", 64'(timeout_err), 64'd1);
        repeat (3) @(negedge clk);
        check("timeout_uu_clear", 64'(n_clr - base), 64'd1);
        check("timeout_idle", 64'(busy), 64'd0);
        check("timeout_step_count", 64'(step_count), 64'd5);
        check("timeout_sticky", 64'(timeout_err), 64'd1);
        hold_done = 1'b0;
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_err", 64'(timeout_err), 64'd0);

        done_lat = 8;
        q_ld.push_back(0);
        q_ld.push_back(1);
        q_st.push_back(0);
        base2 = n_st;
        pulse_grad();
        t = 0;
        while (!(uu_start && mem_layer == 3'd1) && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("clr_reach_layer1", 64'(t < 300), 64'd1);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_busy", 64'(busy), 64'd0);
        check("clr_reqs", 64'({ld_req, st_req, uu_start}), 64'd0);
        check("clr_uu_clear", 64'(uu_clear), 64'd1);
        repeat (12) @(negedge clk);
        check("clr_one_store", 64'(n_st - base2), 64'd1);
        check("clr_step_count", 64'(step_count), 64'd5);
        done_lat = 5;
        push_step(5, 3);
        pulse_grad();
        wait_step("restart_step");

        q_ld.push_back(0);
        base = n_done;
        pulse_grad();
        t = 0;
        while (!st_req && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("rst_reach_store", 64'(st_req), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_store_reqs", 64'({ld_req, st_req, uu_start, uu_clear}), 64'd0);
        check("rst_store_status", 64'({busy, step_done, timeout_err}), 64'd0);
        check("rst_store_count", 64'(step_count), 64'd0);
        check("rst_store_lr", 64'(uu_lr), 64'd0);
        check("rst_store_ts_layer", 64'({uu_timestep, 29'd0, mem_layer}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_no_step_done", 64'(n_done - base), 64'd0);
        check("q_ld_empty", 64'(q_ld.size()), 64'd0);
        check("q_st_empty", 64'(q_st.size()), 64'd0);
        check("q_step_empty", 64'(q_step.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
